instr_fetch_unit: RTL and testbench

- Instruction-fetch and instruction-register (IR) stage directly upstream of the control unit.
- When the control unit requests an instruction with cyc/stb, this block runs a Wishbone-style read cycle on instruction memory at the current PC.
- It latches the returned word into the IR and returns a single-cycle inst_ack.
- It continuously presents the decoded op/func/register fields to the control unit and datapath. A watchdog aborts hung fetches and substitutes a NOP.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and IR stage: runs one instruction-memory read per control-unit request,
// latches the word into the IR and exposes its decoded fields; a watchdog replaces hung fetches with a NOP.
module instr_fetch_unit #(
  parameter int                   INSTR_W   = 18,
  parameter int                   ADDR_W    = 12,
  parameter int                   TIMEOUT   = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 18'h3F000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               inst_ack_o,
  output logic [ADDR_W-1:0]  imem_adr_o,
  output logic               imem_cyc_o,
  output logic               imem_stb_o,
  input  logic [INSTR_W-1:0] imem_dat_i,
  input  logic               imem_ack_i,
  output logic [INSTR_W-1:0] ir_o,
  output logic [6:0]         op_o,
  output logic [3:0]         rd_o,
  output logic [3:0]         rs_o,
  output logic [2:0]         func_o,
  output logic [10:0]        imm_o,
  output logic               fetch_err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                bus_q, bus_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;

  logic req;
  logic wdog_hit;

  assign req      = cyc_i & stb_i;
  assign wdog_hit = (TIMEOUT > 0) && (wdog_q == WDOG_LAST);

  // Abort (request withdrawn) takes priority over a late ack; an ack beats the watchdog.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    bus_d   = bus_q;
    ir_d    = ir_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          adr_d   = pc_i;
          bus_d   = 1'b1;
          wdog_d  = '0;
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
          bus_d   = 1'b0;
        end else if (imem_ack_i) begin
          ir_d    = imem_dat_i;
          bus_d   = 1'b0;
          state_d = DONE;
        end else if (wdog_hit) begin
          ir_d    = NOP_INSTR;
          err_d   = 1'b1;
          bus_d   = 1'b0;
          state_d = DONE;
        end else if (TIMEOUT > 0) begin
          wdog_d  = wdog_q + 1'b1;
        end
      end
      DONE: begin
        if (!stb_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      bus_q   <= 1'b0;
      ir_q    <= NOP_INSTR;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      bus_q   <= bus_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  // Ack is combinational so the control unit advances on the same edge that loads the IR.
  assign inst_ack_o = !rst && (state_q == BUSY) && req && (imem_ack_i || wdog_hit);

  // Gating with rst releases the memory bus without waiting for the reset edge.
  assign imem_cyc_o  = bus_q & ~rst;
  assign imem_stb_o  = bus_q & ~rst;
  assign imem_adr_o  = adr_q;
  assign fetch_err_o = err_q;

  assign ir_o   = ir_q;
  assign op_o   = ir_q[17:11];
  assign rd_o   = ir_q[10:7];
  assign rs_o   = ir_q[6:3];
  assign func_o = ir_q[2:0];
  assign imm_o  = ir_q[10:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit with a 4-cycle watchdog; expected IR words are queued
// as the memory is told what to return and popped once the fetch completes.
module tb_instr_fetch_unit;

  localparam logic [17:0] NOP = 18'h3F000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0;
  logic [11:0] pc_i = '0;
  logic        inst_ack_o;
  logic [11:0] imem_adr_o;
  logic        imem_cyc_o, imem_stb_o;
  logic [17:0] imem_dat_i = '0;
  logic        imem_ack_i = 1'b0;
  logic [17:0] ir_o;
  logic [6:0]  op_o;
  logic [3:0]  rd_o, rs_o;
  logic [2:0]  func_o;
  logic [10:0] imm_o;
  logic        fetch_err_o;

  int vectors = 0;
  int miscompares = 0;
  logic [17:0] expQ[$];
  logic [17:0] exp;
  logic [17:0] lastIr;

  instr_fetch_unit #(.INSTR_W(18), .ADDR_W(12), .TIMEOUT(4), .NOP_INSTR(18'h3F000)) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .pc_i(pc_i),
    .inst_ack_o(inst_ack_o), .imem_adr_o(imem_adr_o), .imem_cyc_o(imem_cyc_o),
    .imem_stb_o(imem_stb_o), .imem_dat_i(imem_dat_i), .imem_ack_i(imem_ack_i),
    .ir_o(ir_o), .op_o(op_o), .rd_o(rd_o), .rs_o(rs_o), .func_o(func_o),
    .imm_o(imm_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the next scoreboard entry and checks the IR and every decoded field against it.
  task automatic popAndCheckIr(input string name);
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s scoreboard: nothing queued, ir=%h", name, ir_o);
    end else begin
      exp = expQ.pop_front();
      if (ir_o !== exp || op_o !== exp[17:11] || rd_o !== exp[10:7] || rs_o !== exp[6:3] ||
          func_o !== exp[2:0] || imm_o !== exp[10:0]) begin
        miscompares++;
        $display("[TB] FAIL %s ir: got ir=%h op=%h rd=%h rs=%h func=%h imm=%h, expected ir=%h",
                 name, ir_o, op_o, rd_o, rs_o, func_o, imm_o, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (ir_o !== NOP || op_o !== 7'b1111110 || func_o !== 3'b000 || imem_cyc_o !== 1'b0 ||
        imem_stb_o !== 1'b0 || imem_adr_o !== 12'h000 || inst_ack_o !== 1'b0 || fetch_err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got ir=%h op=%b func=%b cyc=%b stb=%b adr=%h ack=%b err=%b, expected ir=3f000 op=1111110 rest 0",
               ir_o, op_o, func_o, imem_cyc_o, imem_stb_o, imem_adr_o, inst_ack_o, fetch_err_o);
    end
    rst = 1'b0;
  endtask

  // Single zero-wait fetch from pc; leaves the DUT in IDLE with the request dropped.
  task automatic fetchZeroWait(input string name, input logic [11:0] pc, input logic [17:0] word);
    cyc_i = 1'b1; stb_i = 1'b1; pc_i = pc;
    tick();
    vectors++;
    if (imem_adr_o !== pc || imem_cyc_o !== 1'b1 || imem_stb_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s bus_start: got adr=%h cyc=%b stb=%b, expected adr=%h cyc=1 stb=1",
               name, imem_adr_o, imem_cyc_o, imem_stb_o, pc);
    end
    imem_ack_i = 1'b1; imem_dat_i = word;
    expQ.push_back(word);
    #1;
    vectors++;
    if (inst_ack_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s ack_pulse: got %b expected 1", name, inst_ack_o);
    end
    tick();
    imem_ack_i = 1'b0;
    #1;
    vectors++;
    if (inst_ack_o !== 1'b0 || imem_cyc_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s after_load: got ack=%b cyc=%b expected 0 0", name, inst_ack_o, imem_cyc_o);
    end
    popAndCheckIr(name);
    stb_i = 1'b0; cyc_i = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait();
    fetchZeroWait("zero_wait", 12'h010, 18'h2A5C3);
  endtask

  task automatic test_wait_states();
    cyc_i = 1'b1; stb_i = 1'b1; pc_i = 12'h010;
    lastIr = ir_o;
    tick();
    expQ.push_back(18'h1F0A5);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) pc_i = 12'h0FF;
      if (k == 4) begin imem_ack_i = 1'b1; imem_dat_i = 18'h1F0A5; end
      #1;
      vectors++;
      if (inst_ack_o !== (k == 4) || imem_adr_o !== 12'h010 || (k < 4 && ir_o !== lastIr)) begin
        miscompares++;
        $display("[TB] FAIL wait_cycle%0d: got ack=%b adr=%h ir=%h, expected ack=%b adr=010 ir=%h",
                 k, inst_ack_o, imem_adr_o, ir_o, (k == 4), lastIr);
      end
      tick();
    end
    imem_ack_i = 1'b0;
    popAndCheckIr("wait_states");
    vectors++;
    if (fetch_err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ack_vs_timeout err: got %b expected 0", fetch_err_o);
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    cyc_i = 1'b1; stb_i = 1'b1; pc_i = 12'h020;
    lastIr = ir_o;
    tick();
    tick();
    stb_i = 1'b0; imem_ack_i = 1'b1; imem_dat_i = 18'h00ABC;
    #1;
    vectors++;
    if (inst_ack_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_ack: got %b expected 0", inst_ack_o);
    end
    tick();
    imem_ack_i = 1'b0;
    vectors++;
    if (imem_stb_o !== 1'b0 || imem_cyc_o !== 1'b0 || ir_o !== lastIr) begin
      miscompares++;
      $display("[TB] FAIL abort_after: got stb=%b cyc=%b ir=%h, expected 0 0 %h",
               imem_stb_o, imem_cyc_o, ir_o, lastIr);
    end
    stb_i = 1'b1; pc_i = 12'h030;
    tick();
    vectors++;
    if (imem_cyc_o !== 1'b1 || imem_adr_o !== 12'h030) begin
      miscompares++;
      $display("[TB] FAIL abort_idle_restart: got cyc=%b adr=%h, expected 1 030", imem_cyc_o, imem_adr_o);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    cyc_i = 1'b1; stb_i = 1'b1; pc_i = 12'h040;
    tick();
    expQ.push_back(NOP);
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (inst_ack_o !== (k == 4)) begin
        miscompares++;
        $display("[TB] FAIL watchdog_cycle%0d ack: got %b expected %b", k, inst_ack_o, (k == 4));
      end
      tick();
    end
    popAndCheckIr("watchdog");
    vectors++;
    if (fetch_err_o !== 1'b1 || imem_cyc_o !== 1'b0 || inst_ack_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL watchdog_after: got err=%b cyc=%b ack=%b, expected 1 0 0", fetch_err_o, imem_cyc_o, inst_ack_o);
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    fetchZeroWait("sticky_fetch", 12'h055, 18'h15555);
    cyc_i = 1'b1; stb_i = 1'b1; pc_i = 12'h066;
    tick();
    imem_ack_i = 1'b1; imem_dat_i = 18'h3ACE1;
    expQ.push_back(18'h3ACE1);
    tick();
    popAndCheckIr("hold_load");
    for (int k = 0; k < 3; k++) begin
      imem_dat_i = 18'h01234 + 18'(k);
      #1;
      vectors++;
      if (inst_ack_o !== 1'b0 || imem_cyc_o !== 1'b0 || ir_o !== 18'h3ACE1 || fetch_err_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL done_hold%0d: got ack=%b cyc=%b ir=%h err=%b, expected 0 0 3ace1 1",
                 k, inst_ack_o, imem_cyc_o, ir_o, fetch_err_o);
      end
      tick();
    end
    imem_ack_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    cyc_i = 1'b1; stb_i = 1'b1; pc_i = 12'h050;
    tick();
    rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
    #1;
    vectors++;
    if (imem_cyc_o !== 1'b0 || imem_stb_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus_drop: got cyc=%b stb=%b expected 0 0", imem_cyc_o, imem_stb_o);
    end
    tick();
    rst = 1'b0;
    vectors++;
    if (imem_cyc_o !== 1'b0 || imem_stb_o !== 1'b0 || ir_o !== NOP || fetch_err_o !== 1'b0 || imem_adr_o !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_busy: got cyc=%b stb=%b ir=%h err=%b adr=%h, expected 0 0 3f000 0 000",
               imem_cyc_o, imem_stb_o, ir_o, fetch_err_o, imem_adr_o);
    end
    fetchZeroWait("post_reset", 12'h060, 18'h2BEEF);
    vectors++;
    if (fetch_err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset err: got %b expected 0", fetch_err_o);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_abort();
    test_watchdog();
    test_back_to_back();
    test_reset_mid_busy();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
